timer_sched_arbiter: RTL and testbench

//   Shares one down-counting timer between N requesters. Each requester asks for a

---
 rtl/timer_sched_pkg.sv | 35 +++
 rtl/timer_sched_arbiter_rr_pick.sv | 31 +++
 rtl/timer_sched_arbiter.sv | 135 +++++++++++++
 tb/tb_timer_sched_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_sched_pkg.sv
// Shared types and defaults for the round-robin timer scheduler.
// The optional abort path is enabled with the TIMER_SCHED_ABORT_EN macro.
package timer_sched_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int CNT_W_DEF = 16;
    localparam int IDX_W_DEF = $clog2(N_REQ_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_e;

    // Winner index: first set bit searching last+1, last+2, ... modulo N_REQ_DEF.
    function automatic logic [IDX_W_DEF-1:0] rr_next(
        input logic [N_REQ_DEF-1:0] req,
        input logic [IDX_W_DEF-1:0] last
    );
        logic [IDX_W_DEF-1:0] win;
        logic [IDX_W_DEF-1:0] cand;
        logic                 found;
        win   = '0;
        found = 1'b0;
        for (int i = 1; i <= N_REQ_DEF; i++) begin
            cand = IDX_W_DEF'((int'(last) + i) % N_REQ_DEF);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/timer_sched_arbiter_rr_pick.sv
// Combinational round-robin picker: searches upward from the bit after
// the last winner, wrapping, and reports the first requester found.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        valid  = 1'b0;
        onehot = '0;
        idx    = '0;
        cand   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IDX_W'((int'(last) + i) % N_REQ);
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_sched_arbiter.sv
// One down-counting timer shared round-robin between N_REQ requesters.
// Define TIMER_SCHED_ABORT_EN to add the abort_i cancel port.
module timer_sched_arbiter
    import timer_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic               clk_i,
    input  logic               arst_ni,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*CNT_W-1:0] dur_i,
    output logic [N_REQ-1:0]       gnt_o,
    output logic [N_REQ-1:0]       done_o,
    output logic               busy_o,
    output sched_state_e       state_o
`ifdef TIMER_SCHED_ABORT_EN
    ,
    input  logic [N_REQ-1:0]       abort_i
`endif
);

    // Handshake: req_i is a level sampled only in IDLE; the granted requester
    // holds gnt_o for the whole run, sees done_o for exactly one cycle, and must
    // drop req_i on the following edge or it is treated as a fresh request.

    localparam int                IDX_W    = $clog2(N_REQ);
    localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(N_REQ - 1);

    sched_state_e      state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [IDX_W-1:0]  owner_q, owner_d;

    logic              pick_valid;
    logic [N_REQ-1:0]  pick_onehot;
    logic [IDX_W-1:0]  pick_idx;
    logic [CNT_W-1:0]  pick_dur;
    logic [CNT_W-1:0]  dur_arr [N_REQ];
    logic              abort_hit;

    for (genvar k = 0; k < N_REQ; k++) begin : g_dur
        assign dur_arr[k] = dur_i[k*CNT_W +: CNT_W];
    end

    assign pick_dur = dur_arr[pick_idx];

`ifdef TIMER_SCHED_ABORT_EN
    assign abort_hit = |(abort_i & gnt_q);
`else
    assign abort_hit = 1'b0;
`endif

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (req_i),
        .last   (last_q),
        .valid  (pick_valid),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            count_q <= '0;
            last_q  <= LAST_RST;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            count_q <= count_d;
            last_q  <= last_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        count_d = count_q;
        last_d  = last_q;
        owner_d = owner_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = RUN;
                    gnt_d   = pick_onehot;
                    owner_d = pick_idx;
                    // A zero duration still costs one cycle so done always follows gnt.
                    count_d = (pick_dur == '0) ? CNT_W'(1) : pick_dur;
                end
            end
            RUN: begin
                // Expiry takes precedence over a same-cycle abort.
                if (count_q <= CNT_W'(1)) begin
                    state_d = DONE;
                    done_d  = gnt_q;
                    count_d = '0;
                end else if (abort_hit) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    count_d = '0;
                    last_d  = owner_q;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                last_d  = owner_q;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                count_d = '0;
            end
        endcase
    end

    assign gnt_o   = gnt_q;
    assign done_o  = done_q;
    assign busy_o  = (state_q != IDLE);
    assign state_o = state_q;

endmodule

// File: tb/tb_timer_sched_arbiter.sv
// Self-checking bench for timer_sched_arbiter: vector table, directed corner
// sequences (long duration, reset mid-run, abort when enabled) and random traffic.
module tb_timer_sched_arbiter;
    import timer_sched_pkg::*;

    localparam int N     = 4;
    localparam int W     = 16;
    localparam int MAXD  = 8;
    localparam int BOUND = N * (MAXD + 2);
    localparam int NVEC  = 25;
    localparam int NRND  = 4000;

    logic           clk_i = 1'b0;
    logic           arst_ni;
    logic [N-1:0]   req_i;
    logic [N*W-1:0] dur_i;
    logic [N-1:0]   gnt_o;
    logic [N-1:0]   done_o;
    logic           busy_o;
    sched_state_e   state_o;
`ifdef TIMER_SCHED_ABORT_EN
    logic [N-1:0]   abort_i;
`endif

    int tests = 0;
    int fails = 0;
    logic [N-1:0] exp_q[$];

    typedef struct {
        logic [N-1:0]   req;
        logic [N*W-1:0] dur;
        logic [N-1:0]   gnt;
        logic [N-1:0]   done;
        logic           busy;
    } vec_t;

    vec_t vecs [NVEC];

    timer_sched_arbiter #(
        .N_REQ (N),
        .CNT_W (W)
    ) dut (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .req_i   (req_i),
        .dur_i   (dur_i),
        .gnt_o   (gnt_o),
        .done_o  (done_o),
        .busy_o  (busy_o),
        .state_o (state_o)
`ifdef TIMER_SCHED_ABORT_EN
        ,
        .abort_i (abort_i)
`endif
    );

    // Clock and watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        arst_ni = 1'b0;
        req_i   = '0;
        dur_i   = '0;
`ifdef TIMER_SCHED_ABORT_EN
        abort_i = '0;
`endif
        step();
        step();
        arst_ni = 1'b1;
        step();
    endtask

    task automatic wait_gnt(input string name, input int limit);
        int w;
        w = 0;
        while (gnt_o == '0 && w < limit) begin
            step();
            w++;
        end
        check({name, "_gnt_seen"}, 32'(gnt_o != '0), 32'(1));
    endtask

    task automatic wait_done(input string name, input int limit, output int cyc);
        cyc = 0;
        while (done_o == '0 && cyc < limit) begin
            step();
            cyc++;
        end
        check({name, "_done_seen"}, 32'(done_o != '0), 32'(1));
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[k]) return k;
        return 0;
    endfunction

    task automatic set_vec(input int i, input logic [N-1:0] rq, input logic [N*W-1:0] du,
                           input logic [N-1:0] g, input logic [N-1:0] d, input logic b);
        vecs[i] = '{req: rq, dur: du, gnt: g, done: d, busy: b};
    endtask

    initial begin
        logic [N*W-1:0] d5, d0, d2;
        logic [N-1:0]   e;
        logic           seen;
        int             cyc;

        d5 = 64'h0000_0000_0000_0005;
        d0 = 64'h0007_0000_0007_0007;
        d2 = 64'h0002_0002_0002_0002;
        // single run dur 5, then dur 0 on requester 2, then pointer walk 3 -> 0 -> 1
        set_vec(0,  4'b0001, d5, 4'b0000, 4'b0000, 1'b0);
        set_vec(1,  4'b0001, d5, 4'b0001, 4'b0000, 1'b1);
        set_vec(2,  4'b0001, d5, 4'b0001, 4'b0000, 1'b1);
        set_vec(3,  4'b0001, d5, 4'b0001, 4'b0000, 1'b1);
        set_vec(4,  4'b0001, d5, 4'b0001, 4'b0000, 1'b1);
        set_vec(5,  4'b0001, d5, 4'b0001, 4'b0000, 1'b1);
        set_vec(6,  4'b0000, d5, 4'b0001, 4'b0001, 1'b1);
        set_vec(7,  4'b0000, d5, 4'b0000, 4'b0000, 1'b0);
        set_vec(8,  4'b0100, d0, 4'b0000, 4'b0000, 1'b0);
        set_vec(9,  4'b0100, d0, 4'b0100, 4'b0000, 1'b1);
        set_vec(10, 4'b0000, d0, 4'b0100, 4'b0100, 1'b1);
        set_vec(11, 4'b0000, d0, 4'b0000, 4'b0000, 1'b0);
        set_vec(12, 4'b1011, d2, 4'b0000, 4'b0000, 1'b0);
        set_vec(13, 4'b1011, d2, 4'b1000, 4'b0000, 1'b1);
        set_vec(14, 4'b1011, d2, 4'b1000, 4'b0000, 1'b1);
        set_vec(15, 4'b0011, d2, 4'b1000, 4'b1000, 1'b1);
        set_vec(16, 4'b0011, d2, 4'b0000, 4'b0000, 1'b0);
        set_vec(17, 4'b0011, d2, 4'b0001, 4'b0000, 1'b1);
        set_vec(18, 4'b0011, d2, 4'b0001, 4'b0000, 1'b1);
        set_vec(19, 4'b0010, d2, 4'b0001, 4'b0001, 1'b1);
        set_vec(20, 4'b0010, d2, 4'b0000, 4'b0000, 1'b0);
        set_vec(21, 4'b0010, d2, 4'b0010, 4'b0000, 1'b1);
        set_vec(22, 4'b0010, d2, 4'b0010, 4'b0000, 1'b1);
        set_vec(23, 4'b0000, d2, 4'b0010, 4'b0010, 1'b1);
        set_vec(24, 4'b0000, d2, 4'b0000, 4'b0000, 1'b0);

        // Reset state
        arst_ni = 1'b0;
        req_i   = '0;
        dur_i   = '0;
`ifdef TIMER_SCHED_ABORT_EN
        abort_i = '0;
`endif
        #1;
        check("rst_gnt", 32'(gnt_o), 32'(0));
        check("rst_done", 32'(done_o), 32'(0));
        check("rst_busy", 32'(busy_o), 32'(0));
        check("rst_state", 32'(state_o), 32'(IDLE));
        do_reset();

        // Vector table
        for (int i = 0; i < NVEC; i++) begin
            req_i = vecs[i].req;
            dur_i = vecs[i].dur;
            check($sformatf("vec%0d_gnt", i), 32'(gnt_o), 32'(vecs[i].gnt));
            check($sformatf("vec%0d_done", i), 32'(done_o), 32'(vecs[i].done));
            check($sformatf("vec%0d_busy", i), 32'(busy_o), 32'(vecs[i].busy));
            step();
        end

        // All four held, dur 3: grant order 0,1,2,3,0
        do_reset();
        req_i = 4'b1111;
        dur_i = {4{16'd3}};
        exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int r = 0; r < 5; r++) begin
            wait_gnt($sformatf("rr%0d", r), 20);
            e = exp_q.pop_front();
            check($sformatf("rr%0d_gnt", r), 32'(gnt_o), 32'(e));
            wait_done($sformatf("rr%0d", r), 10, cyc);
            check($sformatf("rr%0d_latency", r), 32'(cyc), 32'(3));
            check($sformatf("rr%0d_done", r), 32'(done_o), 32'(e));
            if (r == 4) req_i = '0;
            step();
        end
        check("rr_idle_busy", 32'(busy_o), 32'(0));

        // Maximum duration on requester 1
        req_i = 4'b0010;
        dur_i = 64'h0000_0000_FFFF_0000;
        wait_gnt("max", 5);
        check("max_gnt", 32'(gnt_o), 32'(4'b0010));
        wait_done("max", 70000, cyc);
        check("max_latency", 32'(cyc), 32'(65535));
        check("max_done", 32'(done_o), 32'(4'b0010));
        req_i = '0;
        step();
        check("max_idle_busy", 32'(busy_o), 32'(0));

        // Reset pulse mid-run at count 2
        do_reset();
        req_i = 4'b0100;
        dur_i = 64'h0000_0006_0000_0000;
        wait_gnt("arst", 5);
        repeat (4) step();
        check("arst_pre_busy", 32'(busy_o), 32'(1));
        arst_ni = 1'b0;
        req_i   = '0;
        #1;
        check("arst_gnt", 32'(gnt_o), 32'(0));
        check("arst_done", 32'(done_o), 32'(0));
        check("arst_busy", 32'(busy_o), 32'(0));
        step();
        arst_ni = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            seen |= (done_o != '0);
            step();
        end
        check("arst_no_done", 32'(seen), 32'(0));
        req_i = 4'b1111;
        dur_i = {4{16'd1}};
        wait_gnt("arst_after", 5);
        check("arst_first_gnt", 32'(gnt_o), 32'(4'b0001));
        wait_done("arst_after", 5, cyc);
        req_i = '0;
        step();

        // Owner drops req mid-run; timer still completes (last winner is 0)
        req_i = 4'b0001;
        dur_i = 64'h0000_0000_0000_0006;
        wait_gnt("drop", 5);
        repeat (2) step();
        req_i = '0;
        wait_done("drop", 10, cyc);
        check("drop_latency", 32'(cyc + 2), 32'(6));
        check("drop_done", 32'(done_o), 32'(4'b0001));
        step();
        check("drop_idle_busy", 32'(busy_o), 32'(0));

`ifdef TIMER_SCHED_ABORT_EN
        // Non-owner abort ignored, owner abort at count 4 cancels silently
        req_i = 4'b0010;
        dur_i = 64'h0000_0000_0008_0000;
        wait_gnt("abort", 5);
        repeat (2) step();
        abort_i = 4'b1101;
        step();
        abort_i = '0;
        step();
        check("abort_nonowner_busy", 32'(busy_o), 32'(1));
        abort_i = 4'b0010;
        req_i   = '0;
        step();
        abort_i = '0;
        check("abort_busy", 32'(busy_o), 32'(0));
        check("abort_gnt", 32'(gnt_o), 32'(0));
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen |= (done_o != '0);
            step();
        end
        check("abort_no_done", 32'(seen), 32'(0));

        // Abort when count is 1: expiry wins
        req_i = 4'b0100;
        dur_i = 64'h0000_0003_0000_0000;
        wait_gnt("abort1", 5);
        check("abort1_gnt", 32'(gnt_o), 32'(4'b0100));
        repeat (2) step();
        abort_i = 4'b0100;
        step();
        abort_i = '0;
        req_i   = '0;
        check("abort1_done", 32'(done_o), 32'(4'b0100));
        step();
        check("abort1_idle_busy", 32'(busy_o), 32'(0));
`endif

        // Random traffic with a reference model of grant/done timing
        do_reset();
        begin
            logic [N-1:0] rq;
            logic [N-1:0] g, d, exp_d;
            int           dur_v [N];
            int           wait_c [N];
            logic         active, free_next;
            int           owner, gcyc, elen;
            rq        = '0;
            active    = 1'b0;
            free_next = 1'b0;
            owner     = 0;
            gcyc      = 0;
            elen      = 1;
            for (int k = 0; k < N; k++) begin
                dur_v[k]  = 0;
                wait_c[k] = 0;
            end
            for (int c = 0; c < NRND; c++) begin
                logic [N-1:0] dropped;
                dropped = '0;
                g = gnt_o;
                d = done_o;
                check("rnd_gnt_onehot0", 32'($onehot0(g)), 32'(1));
                check("rnd_done_in_gnt", 32'((d & ~g) == '0), 32'(1));
                check("rnd_busy", 32'(busy_o), 32'(g != '0));
                if (free_next) begin
                    check("rnd_gnt_free", 32'(g), 32'(0));
                    free_next = 1'b0;
                end else if (active) begin
                    check("rnd_gnt_hold", 32'(g), 32'(1 << owner));
                end else if (g != '0) begin
                    check("rnd_gnt_to_req", 32'((g & rq) == g), 32'(1));
                    owner  = idx_of(g);
                    active = 1'b1;
                    gcyc   = c;
                    elen   = (dur_v[owner] == 0) ? 1 : dur_v[owner];
                    check("rnd_wait_bound", 32'(wait_c[owner] <= BOUND), 32'(1));
                    wait_c[owner] = 0;
                end
                exp_d = (active && (c - gcyc) == elen) ? N'(1 << owner) : '0;
                check("rnd_done", 32'(d), 32'(exp_d));
                if (active && (c - gcyc) == elen) begin
                    active        = 1'b0;
                    free_next     = 1'b1;
                    rq[owner]     = 1'b0;
                    dropped[owner] = 1'b1;
                end
                if (active && rq[owner] && $urandom_range(0, 7) == 0) begin
                    rq[owner] = 1'b0;
                    dropped[owner] = 1'b1;
                end
                for (int k = 0; k < N; k++) begin
                    if (rq[k] && !g[k]) wait_c[k]++;
                    if (!rq[k] && !dropped[k] && !(active && owner == k) &&
                        $urandom_range(0, 3) == 0) begin
                        rq[k]     = 1'b1;
                        dur_v[k]  = int'($urandom_range(0, MAXD));
                        wait_c[k] = 0;
                        dur_i[k*W +: W] = W'(dur_v[k]);
                    end
                end
                req_i = rq;
                step();
            end
            for (int k = 0; k < N; k++) begin
                if (rq[k]) check($sformatf("rnd_final_wait%0d", k), 32'(wait_c[k] <= BOUND), 32'(1));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
